// File: rtl/fw_pkg.sv
// Shared floyd_warshall constants and the loader FSM state encoding.
package fw_pkg;
  localparam int FW_N      = 8;
  localparam int FW_WIDTH  = 32;
  localparam int FW_ADDR_W = $clog2(FW_N * FW_N);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    KICK,
    RUN
  } fw_loader_state_e;
endpackage

// File: rtl/fw_path_loader.sv
// Streams an N*N distance matrix into the path memory, kicks the kernel and waits for it.
// Optional RUN watchdog: define FW_LOADER_TIMEOUT_EN.
module fw_path_loader
  import fw_pkg::*;
#(
  parameter int  WIDTH          = FW_WIDTH,
  parameter int  N              = FW_N,
  parameter int  TIMEOUT_CYCLES = 4096,
  localparam int ADDR_W         = $clog2(N * N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  output logic              in_ready,
  output logic              path_wr_en,
  output logic [ADDR_W-1:0] path_wr_addr,
  output logic [WIDTH-1:0]  path_wr_data,
  output logic              kernel_start,
  input  logic              kernel_done,
  output logic              busy,
  output logic              done,
  output logic              timeout
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N * N - 1);

  fw_loader_state_e  state;
  logic [ADDR_W-1:0] cnt;
  logic              expire;

  assign in_ready = (state == LOAD);
  assign busy     = (state != IDLE);

`ifdef FW_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] run_cnt;

  // KICK counts as the first elapsed cycle, so expiry lands exactly TIMEOUT_CYCLES after KICK
  assign expire = (run_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      if (state == KICK)     run_cnt <= TW'(1);
      else if (state == RUN) run_cnt <= run_cnt + TW'(1);
      if (state == IDLE && load_req)                 timeout <= 1'b0;
      else if (state == RUN && !kernel_done && expire) timeout <= 1'b1;
    end
  end
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      path_wr_en   <= 1'b0;
      path_wr_addr <= '0;
      path_wr_data <= '0;
      kernel_start <= 1'b0;
      done         <= 1'b0;
    end else begin
      path_wr_en   <= 1'b0;
      kernel_start <= 1'b0;
      done         <= 1'b0;
      unique case (state)
        IDLE: if (load_req) begin
          state <= LOAD;
          cnt   <= '0;
        end
        LOAD: if (in_valid) begin
          path_wr_en   <= 1'b1;
          path_wr_addr <= cnt;
          path_wr_data <= in_data;
          cnt          <= cnt + ADDR_W'(1);
          if (cnt == LAST) state <= DRAIN;
        end
        DRAIN: begin
          state        <= KICK;
          kernel_start <= 1'b1;
        end
        KICK: state <= RUN;
        RUN: begin
          if (kernel_done) begin
            state <= IDLE;
            done  <= 1'b1;
          end else if (expire) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fw_path_loader.sv
// Directed bench for fw_path_loader: table of load scenarios plus reset/timeout sequences.
module tb_fw_path_loader;
  localparam int W  = 32;
  localparam int NN = 64;
`ifdef FW_LOADER_TIMEOUT_EN
  localparam int DD = 5;
`else
  localparam int DD = 100;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_req = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready;
  logic          path_wr_en;
  logic [5:0]    path_wr_addr;
  logic [W-1:0]  path_wr_data;
  logic          kernel_start;
  logic          kernel_done = 1'b0;
  logic          busy;
  logic          done;
  logic          timeout;

  fw_path_loader #(.WIDTH(W), .N(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .load_req(load_req), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .path_wr_en(path_wr_en), .path_wr_addr(path_wr_addr),
    .path_wr_data(path_wr_data), .kernel_start(kernel_start), .kernel_done(kernel_done),
    .busy(busy), .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  int gen    = 0;
  int wr_cnt = 0;
  logic [W-1:0] mem [NN];
  int           mem_gen [NN];

  // Path memory model, sampled mid-cycle when the write port is stable
  always @(negedge clk) begin
    if (path_wr_en === 1'b1) begin
      mem[path_wr_addr]     <= path_wr_data;
      mem_gen[path_wr_addr] <= gen;
      wr_cnt                <= wr_cnt + 1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] word_of(input int i, input bit a5);
    if (a5) return 32'hA5;
    return (i == 32) ? '0 : W'(i + 1);
  endfunction

  function automatic logic [63:0] all_outs();
    return {20'd0, in_ready, path_wr_en, path_wr_addr, path_wr_data,
            kernel_start, busy, done, timeout};
  endfunction

  // Entered and left at #1 after a rising edge with the DUT idle (unless aborted).
  // dd<0 skips kernel_done and exercises the watchdog instead.
  task automatic run_load(input int gap, input int abort_at, input bit a5,
                          input int exp_start, input bit kd_at_kick, input int dd);
    int cyc = 0, k = 0, start = -1, viol = 0, wr0;
    bit prev_beat = 0;
    logic [5:0]   prev_k = '0;
    logic [W-1:0] prev_d = '0;
    gen++;
    wr0 = wr_cnt;
    load_req = 1'b1;
    while (start < 0 && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      load_req    = 1'b0;
      kernel_done = 1'b0;
      if (path_wr_en !== prev_beat ||
          (prev_beat && (path_wr_addr !== prev_k || path_wr_data !== prev_d))) viol++;
      if (kernel_start === 1'b1) start = cyc;
      if (abort_at != 0 && k == abort_at) begin
        in_valid = 1'b0;
        chk("wr_port_pre_abort", 64'(viol), 64'd0);
        chk("busy_pre_abort", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1 chk("async_reset_outs", all_outs(), 64'd0);
        #3 rst = 1'b0;
        return;
      end
      in_valid = (k < NN) && (gap == 0 || ((cyc - 1) % gap) != gap - 1);
      in_data  = word_of(k, a5);
      prev_beat = in_valid && in_ready;
      prev_k    = k[5:0];
      prev_d    = in_data;
      if (prev_beat) k++;
      if (start == cyc && kd_at_kick) kernel_done = 1'b1;
    end
    in_valid = 1'b0;
    chk("start_cycle", 64'(start), 64'(exp_start));
    chk("wr_port_seq", 64'(viol), 64'd0);
    @(posedge clk); #1;
    kernel_done = 1'b0;
    chk("start_one_cycle", {kernel_start, busy}, 2'b01);
    if (dd < 0) begin
      repeat (14) @(posedge clk);
      #1 chk("wd_pre", {timeout, busy}, 2'b01);
      @(posedge clk); #1;
      chk("wd_fire", {timeout, busy, done}, 3'b100);
      @(posedge clk); #1;
      chk("wd_sticky", {timeout, busy}, 2'b10);
      load_req = 1'b1;
      @(posedge clk); #1;
      load_req = 1'b0;
      chk("wd_clear", {timeout, busy}, 2'b01);
      #2 rst = 1'b1;
      #3 rst = 1'b0;
      @(posedge clk); #1;
      return;
    end
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
    repeat (dd - 2) @(posedge clk);
    #1 chk("run_busy", {busy, done}, 2'b10);
    kernel_done = 1'b1;
    @(posedge clk); #1;
    kernel_done = 1'b0;
    chk("done_pulse", {done, busy, timeout}, 3'b100);
    @(posedge clk); #1;
    chk("done_cleared", {done, busy}, 2'b00);
    chk("word_count", 64'(wr_cnt - wr0), 64'(NN));
    for (int i = 0; i < NN; i++)
      chk($sformatf("mem[%0d]", i), {mem_gen[i] == gen, mem[i]}, {1'b1, word_of(i, a5)});
  endtask

  typedef struct {
    int gap;
    bit kd_at_kick;
    int exp_start;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got hung want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t tbl[4];
    tbl[0] = '{gap: 0, kd_at_kick: 1'b0, exp_start: 66};
    tbl[1] = '{gap: 3, kd_at_kick: 1'b1, exp_start: 97};
    tbl[2] = '{gap: 2, kd_at_kick: 1'b0, exp_start: 129};
    tbl[3] = '{gap: 4, kd_at_kick: 1'b0, exp_start: 87};

    #3 chk("reset_outs", all_outs(), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_outs", all_outs(), 64'd0);

    foreach (tbl[v])
      run_load(tbl[v].gap, 0, 1'b0, tbl[v].exp_start, tbl[v].kd_at_kick, DD);

    // Abort mid-load, then a clean reload must start again at address 0
    run_load(0, 20, 1'b0, 0, 1'b0, DD);
    @(posedge clk); #1;
    chk("post_reset_idle", all_outs(), 64'd0);
    run_load(0, 0, 1'b1, 66, 1'b0, DD);

`ifdef FW_LOADER_TIMEOUT_EN
    run_load(0, 0, 1'b0, 66, 1'b0, -1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
